// File: rtl/la_usbrx.sv
// la_usbrx -- USB full-speed receive front end.
//
// Oversamples the D+/D- pair at 4x the bit rate, recovers a sample point
// from line transitions, decodes NRZI, strips stuffed bits and delivers
// bytes together with SYNC/EOP/error framing strobes.
//
// Ports:
//   clk        core clock, 4x the USB bit rate
//   reset      synchronous active-high reset
//   rx_en      receive enable; low forces IDLE and silences all strobes
//   usb_dp_in  raw asynchronous D+ line
//   usb_dn_in  raw asynchronous D- line
//   rx_active  high from SYNC completion until EOP or error
//   rx_valid   one-cycle strobe, rx_data holds a new byte
//   rx_data    last received byte (LSB first on the wire)
//   rx_error   one-cycle strobe on stuff, SE1 or alignment error
//   rx_eop     one-cycle strobe on a clean end of packet
module la_usbrx #(
  parameter TARGET = "DEFAULT"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       usb_dp_in,
  input  logic       usb_dn_in,
  output logic       rx_active,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error,
  output logic       rx_eop
);

  // The target string only selects vendor flavours elsewhere; the receive
  // logic is identical for every target.
  if (TARGET == "DEFAULT") begin : g_target_default
  end else begin : g_target_custom
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } state_t;

  logic       dp_meta, dn_meta;
  logic       dp_s, dn_s;
  logic       dp_p, dn_p;
  logic [1:0] phase_q;
  logic [1:0] phase;
  logic       line_changed;
  logic       sample;
  logic       is_j, is_k, is_se0, is_se1;
  logic       nrzi_bit;

  state_t     state, state_n;
  logic       prev_k, prev_k_n;
  logic [2:0] zero_cnt, zero_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [2:0] ones_cnt, ones_cnt_n;
  logic [7:0] shift_reg, shift_reg_n;
  logic [1:0] se0_cnt, se0_cnt_n;
  logic       eop_long, eop_long_n;
  logic       align_err, align_err_n;
  logic [2:0] err_jcnt, err_jcnt_n;
  logic       active_n, valid_n, error_n, eop_n;
  logic [7:0] data_n;

  // Two-flop synchronizers plus a copy of the previous synchronized pair.
  // The phase counter restarts on every line transition so the sample point
  // lands two clocks after each edge, i.e. near the middle of the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_meta <= 1'b1;
      dn_meta <= 1'b0;
      dp_s    <= 1'b1;
      dn_s    <= 1'b0;
      dp_p    <= 1'b1;
      dn_p    <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      dp_meta <= usb_dp_in;
      dn_meta <= usb_dn_in;
      dp_s    <= dp_meta;
      dn_s    <= dn_meta;
      dp_p    <= dp_s;
      dn_p    <= dn_s;
      phase_q <= phase + 2'd1;
    end
  end

  // The phase seen this cycle reads zero on the cycle a transition shows up,
  // so the restart takes effect without an extra cycle of latency.
  always_comb begin
    line_changed = (dp_s != dp_p) || (dn_s != dn_p);
    phase        = line_changed ? 2'd0 : phase_q;
    sample       = (phase == 2'd2);
    is_j         = dp_s & ~dn_s;
    is_k         = ~dp_s & dn_s;
    is_se0       = ~dp_s & ~dn_s;
    is_se1       = dp_s & dn_s;
    nrzi_bit     = (is_k == prev_k);
  end

  // Receive state register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prev_k    <= 1'b0;
      zero_cnt  <= 3'd0;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 3'd0;
      shift_reg <= 8'h00;
      se0_cnt   <= 2'd0;
      eop_long  <= 1'b0;
      align_err <= 1'b0;
      err_jcnt  <= 3'd0;
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      rx_eop    <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      state     <= state_n;
      prev_k    <= prev_k_n;
      zero_cnt  <= zero_cnt_n;
      bit_cnt   <= bit_cnt_n;
      ones_cnt  <= ones_cnt_n;
      shift_reg <= shift_reg_n;
      se0_cnt   <= se0_cnt_n;
      eop_long  <= eop_long_n;
      align_err <= align_err_n;
      err_jcnt  <= err_jcnt_n;
      rx_active <= active_n;
      rx_valid  <= valid_n;
      rx_error  <= error_n;
      rx_eop    <= eop_n;
      rx_data   <= data_n;
    end
  end

  // Next-state logic. Everything advances only on sample strobes; strobes
  // are computed here and appear on the outputs one clock later.
  always_comb begin
    state_n     = state;
    prev_k_n    = prev_k;
    zero_cnt_n  = zero_cnt;
    bit_cnt_n   = bit_cnt;
    ones_cnt_n  = ones_cnt;
    shift_reg_n = shift_reg;
    se0_cnt_n   = se0_cnt;
    eop_long_n  = eop_long;
    align_err_n = align_err;
    err_jcnt_n  = err_jcnt;
    active_n    = rx_active;
    valid_n     = 1'b0;
    error_n     = 1'b0;
    eop_n       = 1'b0;
    data_n      = rx_data;

    if (sample) begin
      case (state)
        ST_IDLE: begin
          if (is_k) begin
            state_n    = ST_SYNC;
            zero_cnt_n = 3'd0;
            prev_k_n   = 1'b1;
          end
        end

        ST_SYNC: begin
          if (is_j || is_k) begin
            prev_k_n = is_k;
            if (!nrzi_bit) begin
              zero_cnt_n = (zero_cnt == 3'd7) ? 3'd7 : zero_cnt + 3'd1;
            end else if (zero_cnt >= 3'd3) begin
              state_n     = ST_DATA;
              active_n    = 1'b1;
              bit_cnt_n   = 3'd0;
              ones_cnt_n  = 3'd0;
              shift_reg_n = 8'h00;
            end else begin
              state_n  = ST_IDLE;
              prev_k_n = 1'b0;
            end
          end else begin
            state_n  = ST_IDLE;
            prev_k_n = 1'b0;
          end
        end

        ST_DATA: begin
          if (is_j || is_k) begin
            prev_k_n = is_k;
            if (ones_cnt == 3'd6) begin
              // After six ones the transmitter must insert a zero; a one
              // here means the stuffing rule was violated.
              if (!nrzi_bit) begin
                ones_cnt_n = 3'd0;
              end else begin
                error_n    = 1'b1;
                active_n   = 1'b0;
                err_jcnt_n = 3'd0;
                state_n    = ST_ERR;
              end
            end else begin
              shift_reg_n = {nrzi_bit, shift_reg[7:1]};
              ones_cnt_n  = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
              bit_cnt_n   = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_n  = {nrzi_bit, shift_reg[7:1]};
                valid_n = 1'b1;
              end
            end
          end else if (is_se0) begin
            state_n     = ST_EOP;
            se0_cnt_n   = 2'd1;
            eop_long_n  = 1'b0;
            align_err_n = (bit_cnt != 3'd0);
            if (bit_cnt != 3'd0) begin
              error_n  = 1'b1;
              active_n = 1'b0;
            end
          end else begin
            error_n    = 1'b1;
            active_n   = 1'b0;
            err_jcnt_n = 3'd0;
            state_n    = ST_ERR;
          end
        end

        ST_EOP: begin
          if (is_se0) begin
            // A fourth SE0 sample marks a long SE0 (bus reset): keep
            // waiting for J but never report it as a normal EOP.
            if (se0_cnt == 2'd3) begin
              eop_long_n = 1'b1;
            end else begin
              se0_cnt_n = se0_cnt + 2'd1;
            end
          end else if (is_j) begin
            eop_n    = !eop_long && !align_err;
            active_n = 1'b0;
            state_n  = ST_IDLE;
            prev_k_n = 1'b0;
          end else begin
            error_n    = 1'b1;
            active_n   = 1'b0;
            err_jcnt_n = 3'd0;
            state_n    = ST_ERR;
          end
        end

        ST_ERR: begin
          if (is_j) begin
            if (err_jcnt == 3'd6) begin
              err_jcnt_n = 3'd0;
              state_n    = ST_IDLE;
              prev_k_n   = 1'b0;
            end else begin
              err_jcnt_n = err_jcnt + 3'd1;
            end
          end else begin
            err_jcnt_n = 3'd0;
          end
        end

        default: begin
          state_n  = ST_IDLE;
          prev_k_n = 1'b0;
        end
      endcase
    end

    if (!rx_en) begin
      state_n  = ST_IDLE;
      prev_k_n = 1'b0;
      active_n = 1'b0;
      valid_n  = 1'b0;
      error_n  = 1'b0;
      eop_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_la_usbrx.sv
// tb_la_usbrx -- scoreboard bench for la_usbrx.
//
// Packets are described as a list of payload bits; a line encoder turns them
// into J/K/SE0 symbols (SYNC, NRZI, bit stuffing, EOP) and a separate
// reference model predicts the strobes the receiver should emit. A monitor
// process pops predictions whenever the receiver raises a strobe.
module tb_la_usbrx;

  logic       clk;
  logic       reset;
  logic       rx_en;
  logic       usb_dp_in;
  logic       usb_dn_in;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       rx_eop;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  localparam logic [2:0] EV_VALID = 3'b001;
  localparam logic [2:0] EV_ERROR = 3'b010;
  localparam logic [2:0] EV_EOP   = 3'b100;

  typedef struct packed {
    logic [2:0] strobes;
    logic [7:0] data;
    logic       active;
  } exp_t;

  exp_t       exp_q[$];
  bit         data_bits[$];
  logic [1:0] line_q[$];
  int         checks;
  int         failures;

  la_usbrx #(.TARGET("DEFAULT")) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .usb_dp_in (usb_dp_in),
    .usb_dn_in (usb_dn_in),
    .rx_active (rx_active),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_error  (rx_error),
    .rx_eop    (rx_eop)
  );

  // Free-running 4x bit-rate clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports it when it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one line symbol for n clocks; inputs change just after the edge.
  task automatic hold(input logic [1:0] sym, input int n);
    {usb_dp_in, usb_dn_in} = sym;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_bits.push_back(b[i]);
  endtask

  function automatic logic [1:0] flip(input logic [1:0] s);
    return (s == SYM_J) ? SYM_K : SYM_J;
  endfunction

  // Line encoder: SYNC, NRZI payload with optional stuffing, SE0 SE0 J.
  task automatic build_line(input bit stuff_en);
    logic [1:0] level;
    int ones;
    line_q.delete();
    line_q.push_back(SYM_K); line_q.push_back(SYM_J);
    line_q.push_back(SYM_K); line_q.push_back(SYM_J);
    line_q.push_back(SYM_K); line_q.push_back(SYM_J);
    line_q.push_back(SYM_K); line_q.push_back(SYM_K);
    level = SYM_K;
    ones = 0;
    foreach (data_bits[i]) begin
      if (!data_bits[i]) level = flip(level);
      line_q.push_back(level);
      ones = data_bits[i] ? ones + 1 : 0;
      if (stuff_en && ones == 6) begin
        level = flip(level);
        line_q.push_back(level);
        ones = 0;
      end
    end
    line_q.push_back(SYM_SE0);
    line_q.push_back(SYM_SE0);
    line_q.push_back(SYM_J);
  endtask

  // Reference model: whole bytes are delivered; seven unstuffed ones abort
  // with an error; a trailing partial byte turns the EOP into an error.
  task automatic predict(input bit stuff_en);
    exp_t e;
    int ones;
    int nbits;
    logic [7:0] acc;
    ones = 0;
    nbits = 0;
    acc = 8'h00;
    foreach (data_bits[i]) begin
      ones = data_bits[i] ? ones + 1 : 0;
      if (!stuff_en && ones == 7) begin
        e = '{strobes: EV_ERROR, data: 8'h00, active: 1'b0};
        exp_q.push_back(e);
        return;
      end
      acc[nbits % 8] = data_bits[i];
      nbits++;
      if (nbits % 8 == 0) begin
        e = '{strobes: EV_VALID, data: acc, active: 1'b1};
        exp_q.push_back(e);
      end
    end
    if (nbits % 8 != 0) e = '{strobes: EV_ERROR, data: 8'h00, active: 1'b0};
    else e = '{strobes: EV_EOP, data: 8'h00, active: 1'b0};
    exp_q.push_back(e);
  endtask

  // Transmit line_q. Runs of equal symbols form segments; each edge is moved
  // by -1/0/+1 clk, neighbouring edges never moving more than one clk apart.
  task automatic applyStimulus(input bit jitter_en);
    int idx;
    int n;
    int j_prev;
    int j_next;
    logic [1:0] sym;
    idx = 0;
    j_prev = 0;
    while (idx < line_q.size()) begin
      sym = line_q[idx];
      n = 0;
      while (idx < line_q.size() && line_q[idx] == sym) begin
        n++;
        idx++;
      end
      j_next = 0;
      if (jitter_en && idx < line_q.size()) begin
        j_next = int'($urandom_range(0, 2)) - 1;
        if (j_next - j_prev > 1 || j_prev - j_next > 1) j_next = 0;
      end
      hold(sym, 4 * n + j_next - j_prev);
      j_prev = j_next;
    end
    hold(SYM_J, 48);
    checkOutput("pending_events", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_bytes(input bit jitter_en);
    build_line(1'b1);
    predict(1'b1);
    applyStimulus(jitter_en);
  endtask

  // Scoreboard monitor: every strobe must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid || rx_error || rx_eop) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", 32'({rx_eop, rx_error, rx_valid}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("strobes", 32'({rx_eop, rx_error, rx_valid}), 32'(e.strobes));
          checkOutput("rx_active", 32'(rx_active), 32'(e.active));
          if (e.strobes == EV_VALID) checkOutput("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int nbytes;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    rx_en = 1'b1;
    hold(SYM_J, 4);
    checkOutput("reset_active", 32'(rx_active), 32'd0);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_error", 32'(rx_error), 32'd0);
    checkOutput("reset_eop", 32'(rx_eop), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    hold(SYM_J, 40);

    $display("[TB] packet 0xA5");
    data_bits.delete();
    add_byte(8'hA5);
    send_bytes(1'b0);

    $display("[TB] packet 0xFF with stuffed bit");
    data_bits.delete();
    add_byte(8'hFF);
    send_bytes(1'b0);

    $display("[TB] seven ones without stuffing");
    data_bits.delete();
    for (int i = 0; i < 7; i++) data_bits.push_back(1'b1);
    build_line(1'b0);
    predict(1'b0);
    applyStimulus(1'b0);
    checkOutput("active_after_stuff_err", 32'(rx_active), 32'd0);
    data_bits.delete();
    add_byte(8'hA5);
    send_bytes(1'b0);

    $display("[TB] five data bits then EOP");
    data_bits.delete();
    data_bits.push_back(1'b1); data_bits.push_back(1'b0);
    data_bits.push_back(1'b1); data_bits.push_back(1'b1);
    data_bits.push_back(1'b0);
    send_bytes(1'b0);

    $display("[TB] packet 0xA5 with edge jitter");
    data_bits.delete();
    add_byte(8'hA5);
    send_bytes(1'b1);

    $display("[TB] reset during the fourth data bit");
    data_bits.delete();
    add_byte(8'hA5);
    build_line(1'b1);
    for (int k = 0; k < 11; k++) hold(line_q[k], 4);
    hold(line_q[11], 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_active", 32'(rx_active), 32'd0);
    checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
    checkOutput("midreset_error", 32'(rx_error), 32'd0);
    checkOutput("midreset_eop", 32'(rx_eop), 32'd0);
    reset = 1'b0;
    hold(SYM_J, 40);
    data_bits.delete();
    add_byte(8'h3C);
    send_bytes(1'b0);

    $display("[TB] random packets");
    for (int p = 0; p < 8; p++) begin
      data_bits.delete();
      nbytes = int'($urandom_range(1, 3));
      for (int b = 0; b < nbytes; b++) add_byte(8'($urandom));
      send_bytes(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
